// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM states and key classification for the keypad entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_BACK      = 4'hD;
  localparam logic [3:0] KEY_CLEAR     = 4'hE;
  localparam logic [3:0] KEY_ENTER     = 4'hF;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    OFFER   = 2'd2
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces the scanned {valid,code} stream and emits one pulse per debounced press.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_press,
  output logic [3:0] key_press_code
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sample;
  logic [4:0]       cand;
  logic [4:0]       stable;
  logic [4:0]       stable_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             press_c;

  assign sample = {key_valid, key_code};

  // Debounced state follows the candidate on the same edge the counter saturates.
  always_comb begin
    cnt_d    = cnt;
    stable_d = stable;
    if (sample != cand) begin
      cnt_d = '0;
    end else begin
      if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
      if (cnt_d == CNT_MAX) stable_d = cand;
    end
  end

  assign press_c = stable_d[4] & ~stable[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      cand           <= '0;
      cnt            <= '0;
      stable         <= '0;
      key_press      <= 1'b0;
      key_press_code <= '0;
    end else begin
      cand      <= sample;
      cnt       <= cnt_d;
      stable    <= stable_d;
      key_press <= press_c;
      if (press_c) key_press_code <= stable_d[3:0];
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: debounced presses edit a BCD buffer; enter converts it to binary
// over one cycle per digit and offers the result on a valid/ready port.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_DIGITS      = 3,
  parameter int unsigned VALUE_W         = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  output logic                               key_press,
  output logic [3:0]                         key_press_code,
  output logic [4*MAX_DIGITS-1:0]            disp_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    disp_count,
  output logic                               busy,
  output logic                               out_valid,
  output logic [VALUE_W-1:0]                 out_value,
  input  logic                               out_ready
);

  localparam int unsigned BUF_W = 4 * MAX_DIGITS;
  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  entry_state_t       state;
  entry_state_t       state_d;
  logic [BUF_W-1:0]   buf_d;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idx_d;
  logic [VALUE_W-1:0] acc;
  logic [VALUE_W-1:0] acc_d;
  logic [VALUE_W-1:0] acc_next;
  logic [VALUE_W-1:0] out_value_d;
  logic               out_valid_d;
  logic [3:0]         cur_digit;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_press     (key_press),
    .key_press_code(key_press_code)
  );

  // Horner step, oldest digit first: acc*10 + digit without a multiplier.
  assign cur_digit = 4'(disp_bcd >> {idx, 2'b00});
  assign acc_next  = (acc << 3) + (acc << 1) + VALUE_W'(cur_digit);

  always_comb begin
    state_d     = state;
    buf_d       = disp_bcd;
    count_d     = disp_count;
    idx_d       = idx;
    acc_d       = acc;
    out_valid_d = out_valid;
    out_value_d = out_value;
    case (state)
      ENTRY: begin
        if (key_press) begin
          if (is_digit(key_press_code)) begin
            if (disp_count < CNT_W'(MAX_DIGITS)) begin
              buf_d   = (disp_bcd << 4) | BUF_W'(key_press_code);
              count_d = disp_count + CNT_W'(1);
            end
          end else if (key_press_code == KEY_BACK) begin
            if (disp_count != '0) begin
              buf_d   = disp_bcd >> 4;
              count_d = disp_count - CNT_W'(1);
            end
          end else if (key_press_code == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = '0;
          end else if (key_press_code == KEY_ENTER) begin
            if (disp_count != '0) begin
              state_d = CONVERT;
              acc_d   = '0;
              idx_d   = disp_count - CNT_W'(1);
            end
          end
        end
      end
      CONVERT: begin
        acc_d = acc_next;
        if (idx == '0) begin
          state_d     = OFFER;
          out_valid_d = 1'b1;
          out_value_d = acc_next;
        end else begin
          idx_d = idx - CNT_W'(1);
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d     = ENTRY;
          out_valid_d = 1'b0;
          buf_d       = '0;
          count_d     = '0;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTRY;
      disp_bcd   <= '0;
      disp_count <= '0;
      idx        <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_value  <= '0;
    end else begin
      state      <= state_d;
      disp_bcd   <= buf_d;
      disp_count <= count_d;
      idx        <= idx_d;
      acc        <= acc_d;
      busy       <= (state_d != ENTRY);
      out_valid  <= out_valid_d;
      out_value  <= out_value_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry (DEBOUNCE_CYCLES=16, MAX_DIGITS=3).
module tb_keypad_entry;

  localparam int unsigned DB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_press;
  logic [3:0]  key_press_code;
  logic [11:0] disp_bcd;
  logic [1:0]  disp_count;
  logic        busy;
  logic        out_valid;
  logic [9:0]  out_value;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  int press_cnt = 0;
  int xfer_cnt = 0;
  logic [9:0] xfer_val = '0;

  keypad_entry #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_DIGITS     (3),
    .VALUE_W        (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_press     (key_press),
    .key_press_code(key_press_code),
    .disp_bcd      (disp_bcd),
    .disp_count    (disp_count),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_value     (out_value),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_press) press_cnt++;
    if (out_valid && out_ready) begin
      xfer_cnt++;
      xfer_val = out_value;
    end
  end

  task automatic press_key(input logic [3:0] code);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = code;
    repeat (DB + 4) @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic release_key();
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic wait_press(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3 * DB && !seen; i++) begin
      @(negedge clk);
      if (key_press) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (key_press !== 1'b0) begin errors++; $display("FAIL reset_key_press got=%b exp=0", key_press); end
    checks++; if (key_press_code !== 4'h0) begin errors++; $display("FAIL reset_code got=%h exp=0", key_press_code); end
    checks++; if (disp_bcd !== 12'h000) begin errors++; $display("FAIL reset_disp_bcd got=%h exp=000", disp_bcd); end
    checks++; if (disp_count !== 2'd0) begin errors++; $display("FAIL reset_disp_count got=%0d exp=0", disp_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_value !== 10'd0) begin errors++; $display("FAIL reset_out_value got=%0d exp=0", out_value); end
  endtask

  task automatic test_debounce();
    int p0;
    int early;
    p0 = press_cnt;
    early = 0;
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'h5;
    repeat (10) @(posedge clk);
    #1 key_valid = 1'b0; key_code = 4'h0;
    repeat (2) @(posedge clk);
    #1 key_valid = 1'b1; key_code = 4'h5;
    for (int k = 0; k < DB; k++) begin
      @(negedge clk);
      if (key_press) early++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (early !== 0) begin errors++; $display("FAIL debounce_early_pulse got=%0d exp=0", early); end
    checks++; if (key_press !== 1'b1) begin errors++; $display("FAIL debounce_pulse_cycle got=%b exp=1", key_press); end
    checks++; if (key_press_code !== 4'h5) begin errors++; $display("FAIL debounce_code got=%h exp=5", key_press_code); end
    @(negedge clk);
    checks++; if (key_press !== 1'b0) begin errors++; $display("FAIL debounce_single_shot got=%b exp=0", key_press); end
    release_key();
    checks++; if (press_cnt - p0 !== 1) begin errors++; $display("FAIL debounce_count got=%0d exp=1", press_cnt - p0); end
    press_key(4'hE);
  endtask

  task automatic test_entry();
    bit seen;
    int x0;
    press_key(4'h4);
    press_key(4'h7);
    press_key(4'h2);
    checks++; if (disp_bcd !== 12'h472) begin errors++; $display("FAIL entry_bcd got=%h exp=472", disp_bcd); end
    checks++; if (disp_count !== 2'd3) begin errors++; $display("FAIL entry_count got=%0d exp=3", disp_count); end
    out_ready = 1'b1;
    x0 = xfer_cnt;
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'hF;
    wait_press(seen);
    checks++; if (!seen) begin errors++; $display("FAIL entry_enter_timeout got=none exp=press"); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 4)) begin errors++; $display("FAIL entry_valid_p%0d got=%b exp=%b", k, out_valid, (k == 4)); end
      checks++;
      if (busy !== (k <= 4)) begin errors++; $display("FAIL entry_busy_p%0d got=%b exp=%b", k, busy, (k <= 4)); end
      if (k == 4) begin
        checks++; if (out_value !== 10'd472) begin errors++; $display("FAIL entry_value got=%0d exp=472", out_value); end
      end
    end
    checks++; if (disp_count !== 2'd0) begin errors++; $display("FAIL entry_count_after got=%0d exp=0", disp_count); end
    release_key();
    checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL entry_transfers got=%0d exp=1", xfer_cnt - x0); end
  endtask

  task automatic test_edit();
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'hD);
    checks++; if (disp_bcd !== 12'h012) begin errors++; $display("FAIL edit_backspace got=%h exp=012", disp_bcd); end
    press_key(4'h9);
    press_key(4'h9);
    checks++; if (disp_bcd !== 12'h129) begin errors++; $display("FAIL edit_full_drop got=%h exp=129", disp_bcd); end
    checks++; if (disp_count !== 2'd3) begin errors++; $display("FAIL edit_count got=%0d exp=3", disp_count); end
    press_key(4'hE);
    checks++; if (disp_bcd !== 12'h000) begin errors++; $display("FAIL edit_clear_bcd got=%h exp=000", disp_bcd); end
    checks++; if (disp_count !== 2'd0) begin errors++; $display("FAIL edit_clear_count got=%0d exp=0", disp_count); end
    press_key(4'hD);
    checks++; if (disp_count !== 2'd0) begin errors++; $display("FAIL edit_back_empty got=%0d exp=0", disp_count); end
    press_key(4'hF);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL edit_enter_empty busy=%b valid=%b exp=0/0", busy, out_valid); end
  endtask

  task automatic test_backpressure();
    int bad;
    int x0;
    out_ready = 1'b0;
    press_key(4'h0);
    press_key(4'h5);
    checks++; if (disp_bcd !== 12'h005 || disp_count !== 2'd2) begin errors++; $display("FAIL bp_entry bcd=%h count=%0d exp=005/2", disp_bcd, disp_count); end
    x0 = xfer_cnt;
    press_key(4'hF);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_value !== 10'd5 || busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable got=%0d bad cycles exp=0", bad); end
    press_key(4'h3);
    checks++; if (disp_bcd !== 12'h005) begin errors++; $display("FAIL bp_digit_ignored got=%h exp=005", disp_bcd); end
    checks++; if (out_valid !== 1'b1 || out_value !== 10'd5) begin errors++; $display("FAIL bp_held valid=%b value=%0d exp=1/5", out_valid, out_value); end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || disp_count !== 2'd0) begin errors++; $display("FAIL bp_after valid=%b count=%0d exp=0/0", out_valid, disp_count); end
    checks++; if (xfer_cnt - x0 !== 1 || xfer_val !== 10'd5) begin errors++; $display("FAIL bp_transfer n=%0d val=%0d exp=1/5", xfer_cnt - x0, xfer_val); end
  endtask

  task automatic test_held();
    int p0;
    p0 = press_cnt;
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'h8;
    repeat (200) @(posedge clk);
    #1 key_code = 4'h9;
    repeat (2 * DB + 8) @(posedge clk);
    release_key();
    checks++; if (press_cnt - p0 !== 1) begin errors++; $display("FAIL held_presses got=%0d exp=1", press_cnt - p0); end
    checks++; if (key_press_code !== 4'h8) begin errors++; $display("FAIL held_code got=%h exp=8", key_press_code); end
    checks++; if (disp_bcd !== 12'h008) begin errors++; $display("FAIL held_bcd got=%h exp=008", disp_bcd); end
    press_key(4'hE);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int bad;
    int x0;
    out_ready = 1'b0;
    press_key(4'h9);
    press_key(4'h9);
    press_key(4'h9);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 4'hF;
    wait_press(seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_enter_timeout got=none exp=press"); end
    @(posedge clk); #1;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_in_convert got=%b exp=1", busy); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_press !== 1'b0 || key_press_code !== 4'h0 || disp_bcd !== 12'h000 || disp_count !== 2'd0 ||
        busy !== 1'b0 || out_valid !== 1'b0 || out_value !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs press=%b code=%h bcd=%h cnt=%0d busy=%b valid=%b value=%0d exp=all 0",
               key_press, key_press_code, disp_bcd, disp_count, busy, out_valid, out_value);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_value_lost got=%0d bad cycles exp=0", bad); end
    press_key(4'h3);
    checks++; if (disp_bcd !== 12'h003 || disp_count !== 2'd1) begin errors++; $display("FAIL rst_fresh bcd=%h count=%0d exp=003/1", disp_bcd, disp_count); end
    out_ready = 1'b1;
    x0 = xfer_cnt;
    press_key(4'hF);
    checks++; if (xfer_cnt - x0 !== 1 || xfer_val !== 10'd3) begin errors++; $display("FAIL rst_fresh_xfer n=%0d val=%0d exp=1/3", xfer_cnt - x0, xfer_val); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_entry();
    test_edit();
    test_backpressure();
    test_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumes the scanned keypad stream (`key_valid`/`key_code`, refreshed once per 4-cycle scan frame) and turns it into clean, single-shot key presses and a multi-digit decimal number. Debounces and edge-detects presses, and collects up to `MAX_DIGITS` decimal digits with clear and backspace. On enter, it converts the BCD buffer to binary over several cycles and offers the value on a valid/ready port to the game logic.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive identical input samples required before the debounced state changes; must be ≥ 2.
- `MAX_DIGITS`, 3: digit buffer depth.
- `VALUE_W`, 10: output width; must satisfy 2^VALUE_W > 10^MAX_DIGITS − 1.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  scanner: a key is held in the last frame.
- `key_code`  in  4  scanner key code (0–9 digits, A–F commands).
- `key_press`  out  1  one-cycle pulse per debounced press.
- `key_press_code`  out  4  code of the last press; held between pulses.
- `disp_bcd`  out  4*MAX_DIGITS  entered digits, least recent digit in the top nibble, most recent in nibble 0, unused nibbles 0.
- `disp_count`  out  $clog2(MAX_DIGITS+1)  number of digits entered.
- `busy`  out  1  high in CONVERT and OFFER.
- `out_valid`  out  1  value offered.
- `out_value`  out  VALUE_W  binary value of the buffer.
- `out_ready`  in  1  consumer accepts.

## Operation
- Debounce: register `cand = {key_valid,key_code}` and counter `cnt`.
  - Sample differs from `cand`: load `cand`, set `cnt = 0`.
  - Otherwise: increment `cnt`, saturating at `DEBOUNCE_CYCLES−1`.
  - When `cnt` reaches `DEBOUNCE_CYCLES−1`, the debounced state is set to `cand`.
- Press event: the debounced valid bit goes 0→1. This pulses `key_press` and loads `key_press_code`.
  - A code change while the key is still held produces no event.
  - Release produces no event.
- Key actions, applied only in state ENTRY:
  - Digit 0–9: if `disp_count < MAX_DIGITS`, shift `disp_bcd` left one nibble, insert the digit at nibble 0, and increment the count. If the buffer is full, the digit is dropped.
  - D (backspace): shift right one nibble and decrement the count. No-op when the count is 0.
  - E (clear): zero the buffer and the count.
  - F (enter): if `disp_count > 0`, go to CONVERT. If the count is 0, ignored.
  - A, B, C: ignored.
- FSM:
  - ENTRY → CONVERT on a valid enter. Clear `acc`; the digit index starts at the oldest digit.
  - CONVERT: each cycle, `acc = (acc<<3) + (acc<<1) + digit`, computed in VALUE_W bits. Advance toward nibble 0. After `disp_count` cycles → OFFER.
  - OFFER: `out_valid = 1` and `out_value = acc`, both stable until `out_ready`. On handshake, clear the buffer and count → ENTRY.
- All presses during CONVERT and OFFER are dropped. `key_press` still pulses.
- Reset values: every output is 0; FSM = ENTRY; `cand`, `cnt` and the debounced state are 0.
- Reset mid-operation: reset in any state returns to ENTRY with an empty buffer. Any offered value is lost.

## Timing
- Press latency: if the input first holds a new value in cycle t and stays stable, the debounced state updates at the end of cycle t+DEBOUNCE_CYCLES−1, and `key_press` is high in cycle t+DEBOUNCE_CYCLES.
- Digit/backspace/clear: the buffer updates on the clock edge ending the `key_press` cycle and is visible the next cycle.
- Enter pressed in cycle p with N digits:
  - CONVERT occupies cycles p+1 … p+N.
  - `out_valid` is high from cycle p+N+1.
- Handshake is the standard valid/ready rule:
  - Transfer occurs in a cycle with `out_valid && out_ready`.
  - `out_valid` drops the next cycle; the buffer is empty the next cycle.
  - `out_ready` may be high before `out_valid`; the earliest transfer is cycle p+N+1.
- `busy` = (state != ENTRY), registered with the state.

## Structure
- `keypad_pkg`: key constants `KEY_BACK=4'hD`, `KEY_CLEAR=4'hE`, `KEY_ENTER=4'hF`, and the state enum `entry_state_t {ENTRY, CONVERT, OFFER}`.
- Sub-module `keypad_debounce` (parameter `DEBOUNCE_CYCLES`): contains `cand`/`cnt`/debounced state and the press edge detector. It outputs `key_press` and `key_press_code`.
- The entry buffer, FSM and converter stay in `keypad_entry`.

## Test plan
- Debounce: with DEBOUNCE_CYCLES=16, `key_valid=1`, code 5 for 10 cycles, then 0 for 2 cycles, then 1/code 5 for 16 cycles → no pulse from the first burst; exactly one `key_press`, code 5, in the cycle after the 16th stable sample.
- Entry: press 4, 7, 2, then F with `out_ready=1` → `disp_bcd=12'h472` before F; `out_valid` for one cycle with `out_value=472`, 4 cycles after the F pulse; then `disp_count=0`.
- Edit: press 1, 2, 3, D, 9, 9 → fourth digit dropped, `disp_bcd=12'h129`; then E → `disp_bcd=0`, `disp_count=0`; then F → stays in ENTRY, `busy=0`.
- Back-pressure: enter 0, 5, F with `out_ready=0` for 20 cycles → `out_valid` and `out_value=5` stable; digit presses during this time are ignored and `disp_bcd` is unchanged; raise `out_ready` → one transfer.
- Held key: hold 8 for 200 cycles, change the code to 9 while held → exactly one press (8).
- Reset: assert `rst` for one cycle during CONVERT of 9, 9, 9 → the next cycle all outputs are 0 and the state is ENTRY; a fresh press of 3 then works normally.
